wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (memory read data or ALU result) and commits it into a 32-entry general-purpose register file.
- Serves the two ID-stage read ports with internal write-to-read bypass, so a value written in a cycle is visible to a same-cycle read.
- Register $0 reads as zero permanently.

Parameters:
DATA_W, 32, width of each register and of all data paths
ADDR_W, 5, register index width; depth = 2**ADDR_W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
MemWB_RegWrite_in  input  1  writeback enable from MEM/WB
MemWB_MemToReg_in  input  1  1 = write ReadData_in, 0 = write B3Dir_in
ReadData_in  input  DATA_W  memory read data from MEM/WB
B3Dir_in  input  DATA_W  ALU result from MEM/WB
B3Mux_in  input  ADDR_W  destination register index from MEM/WB
RdAddrA_in  input  ADDR_W  ID-stage read index A (rs)
RdAddrB_in  input  ADDR_W  ID-stage read index B (rt)
RdDataA_out  output  DATA_W  read data A
RdDataB_out  output  DATA_W  read data B
WBData_out  output  DATA_W  selected writeback value, for forwarding unit
WBValid_out  output  1  a write is committed this cycle (RegWrite and dest != 0)
WrCount_out  output  16  count of committed writes since reset

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0; WrCount_out 0.
  - Consequently RdDataA_out and RdDataB_out read 0 while reset is held.
  - Reset overrides any write in progress.
  - Deassertion takes effect at the next rising edge only.
- WBData_out = MemToReg ? ReadData_in : B3Dir_in.
  - Purely combinational and always driven, independent of RegWrite.
- WBValid_out = MemWB_RegWrite_in && (B3Mux_in != 0).
  - Combinational.
- Write:
  - On the rising edge with WBValid_out = 1, register[B3Mux_in] <= WBData_out.
  - Latency: 1 edge to the array.
  - Writes to index 0 are dropped; register 0 stays 0.
- WrCount_out:
  - Increments by 1 on each edge with WBValid_out = 1.
  - Wraps 0xFFFF -> 0x0000 with no saturation and no flag.
- Read A/B are combinational, in priority order:
  - Address 0 -> 0, regardless of a pending write to 0.
  - Else if WBValid_out and RdAddr == B3Mux_in -> WBData_out (bypass, same cycle).
  - Else -> register[RdAddr].
- Ports A and B are independent; both may address the same register and both may bypass simultaneously.
- X on MemWB_RegWrite_in is not permitted and is an assertion failure in simulation.
- No stall or flush inputs. Upstream gates RegWrite to 0 for bubbles.
- Reads have no side effects.

Test Plan:
- Reset: assert rst_n=0 mid-run after writing R5=0x1234. -> RdDataA(5)=0 immediately, without waiting for a clock; WrCount_out=0. Deassert, read R5 -> 0.
- ALU writeback: RegWrite=1, MemToReg=0, B3Dir=0xDEADBEEF, B3Mux=8, one edge. -> RdDataA(8)=0xDEADBEEF; WrCount_out=1.
- Load writeback: MemToReg=1, ReadData=0x0000_00FF, B3Dir=0x1111_1111, B3Mux=9. -> R9=0x000000FF; WBData_out=0x000000FF before the edge.
- Same-cycle bypass: R3 holds 0x1. Drive write R3=0x2 with RdAddrA=3 and RdAddrB=3 in the same cycle. -> both outputs 0x2 before the edge; after the edge R3=0x2.
- $0 protection: RegWrite=1, B3Mux=0, B3Dir=0xFFFFFFFF. -> WBValid_out=0; RdDataA(0)=0 before and after the edge; WrCount_out unchanged.
- RegWrite=0 and counter wrap:
  - RegWrite=0, B3Mux=4, B3Dir=0x55. -> R4 unchanged; no bypass.
  - Then 65536 valid writes. -> WrCount_out returns to 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback mux feeding a 2**ADDR_W x DATA_W register file with two bypassed combinational read ports.
// Write lands one edge after WBValid_out; a write is accepted every cycle, with no backpressure.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemWB_RegWrite_in,
    input  logic              MemWB_MemToReg_in,
    input  logic [DATA_W-1:0] ReadData_in,
    input  logic [DATA_W-1:0] B3Dir_in,
    input  logic [ADDR_W-1:0] B3Mux_in,
    input  logic [ADDR_W-1:0] RdAddrA_in,
    input  logic [ADDR_W-1:0] RdAddrB_in,
    output logic [DATA_W-1:0] RdDataA_out,
    output logic [DATA_W-1:0] RdDataB_out,
    output logic [DATA_W-1:0] WBData_out,
    output logic              WBValid_out,
    output logic [15:0]       WrCount_out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [15:0]       r_wr_count;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_valid;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    assign w_wb_data   = MemWB_MemToReg_in ? ReadData_in : B3Dir_in;
    assign w_wb_valid  = MemWB_RegWrite_in && (B3Mux_in != '0);

    assign WBData_out  = w_wb_data;
    assign WBValid_out = w_wb_valid;
    assign WrCount_out = r_wr_count;

    // Entry 0 is never written because w_wb_valid excludes index 0, so it holds its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_wb_valid) begin
            r_regs[B3Mux_in] <= w_wb_data;
            r_wr_count       <= r_wr_count + 16'd1;
        end
    end

    // Bypass is suppressed during reset so both ports read zero while rst_n is low.
    always_comb begin
        w_rd_a = r_regs[RdAddrA_in];
        if (RdAddrA_in == '0 || !rst_n) begin
            w_rd_a = '0;
        end else if (w_wb_valid && (RdAddrA_in == B3Mux_in)) begin
            w_rd_a = w_wb_data;
        end
    end

    always_comb begin
        w_rd_b = r_regs[RdAddrB_in];
        if (RdAddrB_in == '0 || !rst_n) begin
            w_rd_b = '0;
        end else if (w_wb_valid && (RdAddrB_in == B3Mux_in)) begin
            w_rd_b = w_wb_data;
        end
    end

    assign RdDataA_out = w_rd_a;
    assign RdDataB_out = w_rd_b;

    a_regwrite_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(MemWB_RegWrite_in));

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expected values are queued when stimulus is driven and popped at each sample point.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWB_RegWrite_in;
    logic        MemWB_MemToReg_in;
    logic [31:0] ReadData_in;
    logic [31:0] B3Dir_in;
    logic [4:0]  B3Mux_in;
    logic [4:0]  RdAddrA_in;
    logic [4:0]  RdAddrB_in;
    logic [31:0] RdDataA_out;
    logic [31:0] RdDataB_out;
    logic [31:0] WBData_out;
    logic        WBValid_out;
    logic [15:0] WrCount_out;

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .MemWB_RegWrite_in (MemWB_RegWrite_in),
        .MemWB_MemToReg_in (MemWB_MemToReg_in),
        .ReadData_in       (ReadData_in),
        .B3Dir_in          (B3Dir_in),
        .B3Mux_in          (B3Mux_in),
        .RdAddrA_in        (RdAddrA_in),
        .RdAddrB_in        (RdAddrB_in),
        .RdDataA_out       (RdDataA_out),
        .RdDataB_out       (RdDataB_out),
        .WBData_out        (WBData_out),
        .WBValid_out       (WBValid_out),
        .WrCount_out       (WrCount_out)
    );

    always #5 clk = ~clk;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rd,
                         input logic [31:0] b3, input logic [4:0] dst,
                         input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        MemWB_RegWrite_in = we;
        MemWB_MemToReg_in = m2r;
        ReadData_in       = rd;
        B3Dir_in          = b3;
        B3Mux_in          = dst;
        RdAddrA_in        = ra;
        RdAddrB_in        = rb;
    endtask

    // Advance one rising edge, update the reference model, then retire the write request.
    task automatic tick();
        logic        w;
        logic [31:0] v;
        logic [4:0]  d;
        w = MemWB_RegWrite_in && (B3Mux_in != 5'd0) && rst_n;
        v = MemWB_MemToReg_in ? ReadData_in : B3Dir_in;
        d = B3Mux_in;
        @(posedge clk);
        if (w) model[d] = v;
        #1 MemWB_RegWrite_in = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        MemWB_RegWrite_in = 1'b0;
        MemWB_MemToReg_in = 1'b0;
        ReadData_in = '0;
        B3Dir_in = '0;
        B3Mux_in = '0;
        RdAddrA_in = 5'd5;
        RdAddrB_in = 5'd8;
        for (int i = 0; i < 32; i++) model[i] = '0;

        #2;
        push(32'h0); chk("reset_rdA", RdDataA_out);
        push(32'h0); chk("reset_rdB", RdDataB_out);
        push(32'h0); chk("reset_count", {16'h0, WrCount_out});
        @(negedge clk) rst_n = 1'b1;

        // ALU writeback to R8
        drive(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd8, 5'd8, 5'd0);
        #1;
        push(32'hDEADBEEF); chk("alu_wbdata", WBData_out);
        push(32'h1);        chk("alu_wbvalid", {31'h0, WBValid_out});
        push(32'hDEADBEEF); chk("alu_bypassA", RdDataA_out);
        tick();
        push(32'hDEADBEEF); chk("alu_rdA", RdDataA_out);
        push(32'h1);        chk("alu_count", {16'h0, WrCount_out});

        // Load writeback to R9
        drive(1'b1, 1'b1, 32'h000000FF, 32'h11111111, 5'd9, 5'd0, 5'd9);
        #1;
        push(32'h000000FF); chk("load_wbdata", WBData_out);
        tick();
        push(32'h000000FF); chk("load_rdB", RdDataB_out);
        push(32'h2);        chk("load_count", {16'h0, WrCount_out});

        // Same-cycle bypass on both ports
        drive(1'b1, 1'b0, 32'h0, 32'h1, 5'd3, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h2, 5'd3, 5'd3, 5'd3);
        #1;
        push(32'h2); chk("byp_rdA_pre", RdDataA_out);
        push(32'h2); chk("byp_rdB_pre", RdDataB_out);
        tick();
        push(32'h2); chk("byp_rdA_post", RdDataA_out);
        push(32'h4); chk("byp_count", {16'h0, WrCount_out});

        // Write to $0 is dropped
        drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        #1;
        push(32'h0);        chk("r0_wbvalid", {31'h0, WBValid_out});
        push(32'hFFFFFFFF); chk("r0_wbdata", WBData_out);
        push(32'h0);        chk("r0_rdA_pre", RdDataA_out);
        tick();
        push(32'h0); chk("r0_rdA_post", RdDataA_out);
        push(32'h4); chk("r0_count", {16'h0, WrCount_out});

        // RegWrite low: no bypass, no write
        drive(1'b0, 1'b0, 32'h0, 32'h55, 5'd4, 5'd4, 5'd4);
        #1;
        push(32'h0); chk("nowe_wbvalid", {31'h0, WBValid_out});
        push(32'h0); chk("nowe_rdA_pre", RdDataA_out);
        tick();
        push(32'h0); chk("nowe_rdA_post", RdDataB_out);
        push(32'h4); chk("nowe_count", {16'h0, WrCount_out});

        // Asynchronous reset mid-run
        drive(1'b1, 1'b0, 32'h0, 32'h1234, 5'd5, 5'd5, 5'd8);
        tick();
        push(32'h1234); chk("prerst_rdA", RdDataA_out);
        push(32'h5);    chk("prerst_count", {16'h0, WrCount_out});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        push(32'h0); chk("rst_async_rdA", RdDataA_out);
        push(32'h0); chk("rst_async_rdB", RdDataB_out);
        push(32'h0); chk("rst_async_count", {16'h0, WrCount_out});
        drive(1'b1, 1'b0, 32'h0, 32'hABCD, 5'd5, 5'd5, 5'd5);
        #1;
        push(32'h0); chk("rst_pending_rdA", RdDataA_out);
        tick();
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(negedge clk) rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd8);
        #1;
        push(32'h0); chk("postrst_rdA", RdDataA_out);
        push(32'h0); chk("postrst_count", {16'h0, WrCount_out});

        // 65536 valid writes wrap the counter back to zero
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, i[0], $urandom, $urandom, 5'((i % 31) + 1), 5'd0, 5'd0);
            tick();
            if (i == 65534) begin
                push(32'h0000FFFF); chk("count_ffff", {16'h0, WrCount_out});
            end
        end
        push(32'h0); chk("count_wrap", {16'h0, WrCount_out});

        for (int r = 1; r < 32; r++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(r), 5'(32 - r));
            #1;
            push(model[r]);      chk("readback_A", RdDataA_out);
            push(model[32 - r]); chk("readback_B", RdDataB_out);
        end

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL leftover_expected: observed %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
